// File: rtl/pipeline_mem_access.sv
// Memory-stage load/store controller: turns a pipeline load/store into a
// req/ack bus transaction, aligns/extends load data and stalls the pipe.
module pipeline_mem_access #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in_MEM,
  input  logic        MemRead_in_MEM,
  input  logic        MemRW_in_MEM,
  input  logic [2:0]  funct3_in_MEM,
  input  logic [31:0] ALU_in_MEM,
  input  logic [31:0] Data_in_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] DMem_data_MEM,
  output logic        done_MEM,
  output logic        err_MEM,
  output logic        stall_MEM
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q;
  logic [31:0] cnt_q;
  logic [2:0]  f3_q;   // funct3 of the access in flight, used to align load data
  logic [1:0]  off_q;  // byte offset of the access in flight

  logic        mem_op;
  logic        is_store;
  logic        legal;
  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign mem_op   = valid_in_MEM && (MemRead_in_MEM || MemRW_in_MEM);
  assign is_store = MemRW_in_MEM;  // store wins when both are set

  assign stall_MEM = ((state_q == IDLE) && mem_op) || (state_q == REQ);

  // Decode legality and alignment of the op presented in IDLE
  always_comb begin
    legal = 1'b0;
    case (funct3_in_MEM)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;  // unsigned forms are load-only
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (funct3_in_MEM[1:0])
      2'b01:   aligned = !ALU_in_MEM[0];
      2'b10:   aligned = (ALU_in_MEM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store byte lanes and replicated write data
  always_comb begin
    case (funct3_in_MEM[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALU_in_MEM[1:0];
        st_wdata = {4{Data_in_MEM[7:0]}};
      end
      2'b01: begin
        st_be    = ALU_in_MEM[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{Data_in_MEM[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = Data_in_MEM;
      end
    endcase
  end

  // Select and extend the load result from the returned bus word
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Access FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      DMem_data_MEM <= '0;
      done_MEM      <= 1'b0;
      err_MEM       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_MEM <= 1'b0;
          err_MEM  <= 1'b0;
          if (mem_op) begin
            if (legal && aligned) begin
              state_q   <= REQ;
              cnt_q     <= '0;
              f3_q      <= funct3_in_MEM;
              off_q     <= ALU_in_MEM[1:0];
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ALU_in_MEM[31:2], 2'b00};
              mem_be    <= is_store ? st_be : 4'b0000;
              mem_wdata <= is_store ? st_wdata : 32'd0;
            end else begin
              // Rejected without touching the bus
              state_q  <= DONE;
              done_MEM <= 1'b1;
              err_MEM  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q       <= DONE;
            mem_req       <= 1'b0;
            done_MEM      <= 1'b1;
            err_MEM       <= 1'b0;
            DMem_data_MEM <= mem_we ? 32'd0 : ld_val;
          end else if (cnt_q == ACK_TIMEOUT) begin
            state_q       <= DONE;
            mem_req       <= 1'b0;
            done_MEM      <= 1'b1;
            err_MEM       <= 1'b1;
            DMem_data_MEM <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE: begin
          // Always return to IDLE; the op still on the inputs is not re-accepted here
          state_q  <= IDLE;
          done_MEM <= 1'b0;
          err_MEM  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_access.sv
// Randomized bench for pipeline_mem_access with a transaction-level model.
module tb_pipeline_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in_MEM, MemRead_in_MEM, MemRW_in_MEM;
  logic [2:0]  funct3_in_MEM;
  logic [31:0] ALU_in_MEM, Data_in_MEM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, DMem_data_MEM;
  logic [3:0]  mem_be;
  logic        done_MEM, err_MEM, stall_MEM;

  pipeline_mem_access #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in_MEM(valid_in_MEM), .MemRead_in_MEM(MemRead_in_MEM),
    .MemRW_in_MEM(MemRW_in_MEM), .funct3_in_MEM(funct3_in_MEM), .ALU_in_MEM(ALU_in_MEM),
    .Data_in_MEM(Data_in_MEM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .DMem_data_MEM(DMem_data_MEM), .done_MEM(done_MEM), .err_MEM(err_MEM),
    .stall_MEM(stall_MEM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations, written by the stimulus, checked by the compare process
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_req, exp_done, exp_err, exp_bus, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_dmem;
  logic [3:0]  exp_be;

  // Observations of the DUT during the last op, for literal checks
  int          req_seen, done_at;
  bit          err_seen, snap_we;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall_MEM), 32'(exp_stall));
      check("req", 32'(mem_req), 32'(exp_req));
      check("done", 32'(done_MEM), 32'(exp_done));
      check("err", 32'(err_MEM), 32'(exp_err));
      check("dmem", DMem_data_MEM, exp_dmem);
      if (exp_bus) begin
        check("we", 32'(mem_we), 32'(exp_we));
        check("addr", mem_addr, exp_addr);
        check("be", 32'(mem_be), 32'(exp_be));
        if (exp_we) check("wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic set_exp(input bit s, input bit r, input bit d, input bit e);
    exp_stall = s; exp_req = r; exp_done = d; exp_err = e; exp_bus = 1'b0;
  endtask

  // Model: value a load returns for a given bus word
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> (8 * int'(addr[1:0]));
    case (f3)
      3'b000:  return 32'($signed(w[7:0]));
      3'b100:  return w & 32'h0000_00FF;
      3'b001:  return 32'($signed(w[15:0]));
      3'b101:  return w & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  task automatic observe(input int c);
    if (mem_req) begin
      if (req_seen == 0) begin
        snap_we = mem_we; snap_be = mem_be; snap_addr = mem_addr; snap_wdata = mem_wdata;
      end
      req_seen++;
    end
    if (done_MEM && done_at == 0) begin
      done_at  = c;
      err_seen = err_MEM;
    end
  endtask

  task automatic rand_bus();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    valid_in_MEM   = 1'($urandom_range(0, 1));
    MemRead_in_MEM = valid_in_MEM ? 1'b0 : 1'($urandom_range(0, 1));
    MemRW_in_MEM   = valid_in_MEM ? 1'b0 : 1'($urandom_range(0, 1));
    rand_bus();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One memory op; waits < 0 means the ack never arrives
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int waits, input logic [31:0] rdata);
    bit ok, legal, timed;
    int sz, c;
    if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << int'(f3[1:0]);
    ok = legal && (int'(addr[1:0]) % sz == 0);
    req_seen = 0; done_at = 0; err_seen = 1'b0; timed = 1'b0; c = 1;
    @(posedge clk); #1;
    valid_in_MEM = 1'b1; MemRead_in_MEM = rd; MemRW_in_MEM = wr;
    funct3_in_MEM = f3; ALU_in_MEM = addr; Data_in_MEM = data;
    rand_bus();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    observe(c);
    if (!ok) begin
      @(posedge clk); #1; c++;
      rand_bus();
      set_exp(1'b0, 1'b0, 1'b1, 1'b1);
      observe(c);
      return;
    end
    for (int j = 0; ; j++) begin
      @(posedge clk); #1; c++;
      mem_ack   = (waits >= 0 && j == waits);
      mem_rdata = mem_ack ? rdata : $urandom;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
      exp_bus  = 1'b1;
      exp_we   = wr;
      exp_addr = addr & 32'hFFFF_FFFC;
      if (!wr) exp_be = 4'b0000;
      else if (f3 == 3'd0) exp_be = 4'b0001 << addr[1:0];
      else if (f3 == 3'd1) exp_be = 4'b0011 << addr[1:0];
      else exp_be = 4'b1111;
      if (f3 == 3'd0)      exp_wdata = (data & 32'hFF) * 32'h0101_0101;
      else if (f3 == 3'd1) exp_wdata = (data & 32'hFFFF) * 32'h0001_0001;
      else                 exp_wdata = data;
      observe(c);
      if (mem_ack) break;
      if (j == int'(TO)) begin
        timed = 1'b1;
        break;
      end
    end
    @(posedge clk); #1; c++;
    rand_bus();
    set_exp(1'b0, 1'b0, 1'b1, timed);
    exp_dmem = (timed || wr) ? 32'd0 : load_val(f3, addr, rdata);
    observe(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] addr;
    int waits;
    rst = 1'b1; valid_in_MEM = 1'b0; MemRead_in_MEM = 1'b0; MemRW_in_MEM = 1'b0;
    funct3_in_MEM = '0; ALU_in_MEM = '0; Data_in_MEM = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done_MEM), 32'd0);
    check("rst_err", 32'(err_MEM), 32'd0);
    check("rst_stall", 32'(stall_MEM), 32'd0);
    check("rst_dmem", DMem_data_MEM, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;
    exp_dmem = 32'd0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // SW, ack on the first REQ cycle
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
    check("sw_addr", snap_addr, 32'h100);
    check("sw_be", 32'(snap_be), 32'hF);
    check("sw_we", 32'(snap_we), 32'd1);
    check("sw_wdata", snap_wdata, 32'hDEAD_BEEF);
    check("sw_done_cycle", done_at, 3);
    check("sw_req_cycles", req_seen, 1);
    // LB / LBU with two wait cycles
    do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 2, 32'h8012_3456);
    check("lb_val", DMem_data_MEM, 32'hFFFF_FF80);
    check("lb_done_cycle", done_at, 5);
    do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h8012_3456);
    check("lbu_val", DMem_data_MEM, 32'h0000_0080);
    check("lbu_done_cycle", done_at, 5);
    // SH upper half, LHU
    do_op(1'b0, 1'b1, 3'b001, 32'h102, 32'hABCD_1234, 1, 32'h0);
    check("sh_be", 32'(snap_be), 32'hC);
    check("sh_wdata", snap_wdata, 32'h1234_1234);
    check("sh_dmem", DMem_data_MEM, 32'd0);
    do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h9ABC_0000);
    check("lhu_val", DMem_data_MEM, 32'h0000_9ABC);
    // Misaligned LW, illegal store encoding
    do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    check("mis_req", req_seen, 0);
    check("mis_done_cycle", done_at, 2);
    check("mis_err", 32'(err_seen), 32'd1);
    do_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    check("ill_req", req_seen, 0);
    check("ill_done_cycle", done_at, 2);
    check("ill_err", 32'(err_seen), 32'd1);
    // Timeout, then a late ack that must be ignored
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0);
    check("to_req_cycles", req_seen, int'(TO) + 1);
    check("to_done_cycle", done_at, int'(TO) + 3);
    check("to_err", 32'(err_seen), 32'd1);
    check("to_dmem", DMem_data_MEM, 32'd0);
    @(posedge clk); #1;
    valid_in_MEM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_dmem", DMem_data_MEM, 32'd0);

    // Load a nonzero value so the reset clear of DMem is visible
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h5555_AAAA);
    // Reset during the second REQ cycle
    @(posedge clk); #1;
    valid_in_MEM = 1'b1; MemRead_in_MEM = 1'b1; MemRW_in_MEM = 1'b0;
    funct3_in_MEM = 3'b010; ALU_in_MEM = 32'h200; mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    exp_dmem = 32'd0;
    check("post_rst_req", 32'(mem_req), 32'd0);
    check("post_rst_we", 32'(mem_we), 32'd0);
    check("post_rst_addr", mem_addr, 32'd0);
    check("post_rst_be", 32'(mem_be), 32'd0);
    check("post_rst_wdata", mem_wdata, 32'd0);
    check("post_rst_dmem", DMem_data_MEM, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    exp_dmem = 32'h1122_3344;
    check("restart_done", 32'(done_MEM), 32'd1);
    check("restart_dmem", DMem_data_MEM, 32'h1122_3344);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      waits = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_op(rd, wr, f3, addr, $urandom, waits, $urandom);
    end
    idle_cycle();
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_access.md
# pipeline_mem_access

Memory-stage load/store controller that sits between the EX/MEM pipeline register and the data-memory bus. It turns a load or store presented by the pipeline into a request/acknowledge bus transaction, applying byte lanes and store-data replication on the way out. On the way back it aligns and sign- or zero-extends load data. It produces the `DMem_data` value that the write-back mux selects for loads, and it stalls the pipeline until the access completes.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles spent in REQ waiting for `mem_ack` before the access is aborted with an error.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_in_MEM` in 1: an instruction occupies the MEM stage.
- `MemRead_in_MEM` in 1: the instruction is a load.
- `MemRW_in_MEM` in 1: the instruction is a store; if both this and `MemRead_in_MEM` are set, the store wins.
- `funct3_in_MEM` in 3: access width and signedness.
- `ALU_in_MEM` in 32: effective byte address.
- `Data_in_MEM` in 32: store data (rs2).
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, with bits [1:0] forced to 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: replicated store data.
- `mem_ack` in 1: bus completion.
- `mem_rdata` in 32: bus read word.
- `DMem_data_MEM` out 32: aligned and extended load result.
- `done_MEM` out 1: one-cycle completion pulse.
- `err_MEM` out 1: one-cycle error pulse, coincident with `done_MEM`.
- `stall_MEM` out 1: hold the pipeline.

## Operation
- A memory op is `valid_in_MEM && (MemRead_in_MEM || MemRW_in_MEM)`. Non-memory instructions produce no stall and no pulses.
- `funct3` encodings:
  - 000 B, 001 H, 010 W: signed loads / stores.
  - 100 BU, 101 HU: unsigned, loads only.
  - Any other code, or BU/HU on a store, is illegal.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
- Stores:
  - B: `mem_be` = 1<<addr[1:0], `mem_wdata` = {4{byte}}.
  - H: `mem_be` = addr[1] ? 1100 : 0011, `mem_wdata` = {2{half}}.
  - W: `mem_be` = 1111, `mem_wdata` = data.
- Loads: `mem_be` = 0000, `mem_we` = 0. The byte or half is selected from the captured `mem_rdata` by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU).
- FSM states: IDLE, REQ, DONE.
  - IDLE, memory op present, legal and aligned: register the bus outputs, go to REQ, clear the timeout counter.
  - IDLE, memory op present, illegal or misaligned: no bus activity, set the error flag, go to DONE.
  - REQ: `mem_req`=1 with all bus outputs held stable. On `mem_ack`, capture the load result and go to DONE. If the counter reaches `ACK_TIMEOUT`, set the error flag and go to DONE with `DMem_data_MEM`=0. Otherwise increment the counter.
  - DONE: `done_MEM`=1, `err_MEM` = error flag, `mem_req`=0, then go to IDLE. DONE never re-triggers, even though the same op is still on the inputs this cycle.
- `stall_MEM` = (IDLE && memory op) || REQ. It is combinational from the inputs while in IDLE and low in DONE, so the pipeline advances at the end of the DONE cycle.
- `mem_ack` is ignored outside REQ, including a late ack after a timeout or reset.
- `DMem_data_MEM` holds its last value until the next capture. Store completions drive it to 0.
- Reset: state IDLE, all outputs 0, counter 0, error flag 0. Any in-flight transaction is abandoned; `mem_req` is 0 in the cycle after the reset edge.

## Timing
- Minimum access is 3 cycles: IDLE (stall), REQ (ack seen in the same cycle), DONE (pulse, stall low).
- With k wait cycles before `mem_ack`, the access takes 3+k cycles.
- Error without bus access takes 2 cycles: IDLE, DONE.
- Timeout: `err_MEM` pulses ACK_TIMEOUT+2 cycles after the IDLE accept cycle.
- All outputs except `stall_MEM` are registered.

## Test plan
- SW to addr 0x100 with data 0xDEADBEEF, ack on the first REQ cycle -> `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF; `done_MEM` in cycle 3; stall high in cycles 1–2 only.
- LB addr 0x203, `mem_rdata`=0x80123456, ack after 2 wait cycles -> `DMem_data_MEM`=0xFFFFFF80. LBU with the same inputs -> 0x00000080. Both complete in 5 cycles.
- SH addr 0x102 with data 0xABCD1234 -> `mem_be`=1100, `mem_wdata`=0x12341234. LHU addr 0x102, `mem_rdata`=0x9ABC0000 -> 0x00009ABC.
- LW addr 0x101 -> `mem_req` never asserted; `done_MEM`=`err_MEM`=1 in cycle 2. A store with funct3 100 produces the same result.
- `ACK_TIMEOUT`=4, ack never arrives -> `mem_req` high for 5 cycles, then `err_MEM` pulses and `DMem_data_MEM`=0. An ack arriving afterwards changes nothing.
- `rst` asserted during the second REQ cycle -> all outputs 0 on the following cycle, state IDLE. The op still present after `rst` deasserts restarts a fresh 3-cycle access.
